lsu_ctrl: RTL and testbench



---
 rtl/lsu_ctrl_pkg.sv | 38 +++
 rtl/lsu_ctrl_if.sv | 34 +++
 rtl/lsu_ctrl_align.sv | 46 ++++
 rtl/lsu_ctrl.sv | 147 ++++++++++++++
 tb/tb_lsu_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/lsu_ctrl_pkg.sv
// Shared types for the load/store unit: access widths, controller states and RAM opcodes.
// Also holds the alignment rule used by the request error check.
package lsu_ctrl_pkg;

  typedef enum logic [1:0] {
    LSU_B = 2'b00,
    LSU_H = 2'b01,
    LSU_W = 2'b10
  } lsu_width_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LD_RD   = 3'd1,
    LD_CAP  = 3'd2,
    RMW_RD  = 3'd3,
    RMW_MRG = 3'd4,
    ST_WR   = 3'd5,
    RESP    = 3'd6
  } lsu_state_e;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_LOAD  = 2'b01,
    MEM_STORE = 2'b10
  } mem_op_e;

  // Any encoding other than byte/half is held to word alignment.
  function automatic logic is_misaligned(lsu_width_e width, logic [1:0] lane);
    logic mis;
    case (width)
      LSU_B:   mis = 1'b0;
      LSU_H:   mis = lane[0];
      default: mis = (lane != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Bundle of the execute-side request/response handshake and the word RAM port.
// master: the load/store controller; slave: the execute stage plus RAM around it.
interface lsu_ctrl_if;
  import lsu_ctrl_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  lsu_width_e  req_width;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic        resp_oob;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  mem_op_e     mem_op;
  logic [31:0] mem_rdata;

  modport master (
    input  req_valid, req_store, req_width, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_misaligned, resp_oob,
           mem_addr, mem_wdata, mem_op
  );

  modport slave (
    output req_valid, req_store, req_width, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_misaligned, resp_oob,
           mem_addr, mem_wdata, mem_op
  );

endinterface

// File: rtl/lsu_ctrl_align.sv
// Lane logic for sub-word accesses: extracts/extends load data from a RAM word
// and merges store data into a RAM word for read-modify-write.
module lsu_align
  import lsu_ctrl_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  lsu_width_e  width,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Select the addressed lane, then extend for loads or splice for stores.
  always_comb begin
    byte_s    = word[{lane, 3'b000} +: 8];
    half_s    = lane[1] ? word[31:16] : word[15:0];
    load_data = word;
    merged    = wdata;
    case (width)
      LSU_B: begin
        load_data = {{24{byte_s[7] & ~is_unsigned}}, byte_s};
        merged    = word;
        merged[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      LSU_H: begin
        load_data = {{16{half_s[15] & ~is_unsigned}}, half_s};
        merged    = word;
        if (lane[1]) begin
          merged[31:16] = wdata[15:0];
        end else begin
          merged[15:0] = wdata[15:0];
        end
      end
      default: begin
        load_data = word;
        merged    = wdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store initiator between the execute stage and a word-wide RAM with
// registered address and next-cycle read data; sub-word stores use read-modify-write.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int MEM_BYTES = 16384
) (
  input  logic          clk,
  input  logic          rst_n,
  lsu_ctrl_if.master    bus
);

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  lsu_state_e  state_r;
  logic        req_ready_r;
  logic        resp_valid_r;
  logic [31:0] resp_rdata_r;
  logic        resp_mis_r;
  logic        resp_oob_r;
  logic [31:0] mem_addr_r;
  logic [31:0] mem_wdata_r;
  mem_op_e     mem_op_r;
  logic [1:0]  lane_r;
  lsu_width_e  width_r;
  logic        unsigned_r;
  logic [31:0] wdata_r;

  logic        mis_s;
  logic        oob_s;
  logic [31:0] load_data_s;
  logic [31:0] merged_s;

  assign mis_s = is_misaligned(bus.req_width, bus.req_addr[1:0]);
  assign oob_s = (bus.req_addr >= MEM_LIMIT);

  lsu_align u_align (
    .word        (bus.mem_rdata),
    .lane        (lane_r),
    .width       (width_r),
    .is_unsigned (unsigned_r),
    .wdata       (wdata_r),
    .load_data   (load_data_s),
    .merged      (merged_s)
  );

  // Controller FSM; every bus output is a register updated on the transition into its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'h0000_0000;
      resp_mis_r   <= 1'b0;
      resp_oob_r   <= 1'b0;
      mem_addr_r   <= 32'h0000_0000;
      mem_wdata_r  <= 32'h0000_0000;
      mem_op_r     <= MEM_NONE;
      lane_r       <= 2'b00;
      width_r      <= LSU_B;
      unsigned_r   <= 1'b0;
      wdata_r      <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.req_valid && req_ready_r) begin
            req_ready_r <= 1'b0;
            lane_r      <= bus.req_addr[1:0];
            width_r     <= bus.req_width;
            unsigned_r  <= bus.req_unsigned;
            wdata_r     <= bus.req_wdata;
            if (mis_s || oob_s) begin
              state_r      <= RESP;
              resp_valid_r <= 1'b1;
              resp_rdata_r <= 32'h0000_0000;
              resp_mis_r   <= mis_s;
              resp_oob_r   <= oob_s;
            end else if (!bus.req_store) begin
              state_r    <= LD_RD;
              mem_op_r   <= MEM_LOAD;
              mem_addr_r <= {bus.req_addr[31:2], 2'b00};
            end else if (bus.req_width == LSU_W) begin
              state_r     <= ST_WR;
              mem_op_r    <= MEM_STORE;
              mem_addr_r  <= {bus.req_addr[31:2], 2'b00};
              mem_wdata_r <= bus.req_wdata;
            end else begin
              state_r    <= RMW_RD;
              mem_op_r   <= MEM_LOAD;
              mem_addr_r <= {bus.req_addr[31:2], 2'b00};
            end
          end else begin
            state_r <= IDLE;
          end
        end
        LD_RD: begin
          state_r <= LD_CAP;
        end
        LD_CAP: begin
          state_r      <= RESP;
          mem_op_r     <= MEM_NONE;
          resp_valid_r <= 1'b1;
          resp_rdata_r <= load_data_s;
        end
        RMW_RD: begin
          state_r <= RMW_MRG;
        end
        RMW_MRG: begin
          state_r     <= ST_WR;
          mem_op_r    <= MEM_STORE;
          mem_wdata_r <= merged_s;
        end
        ST_WR: begin
          state_r      <= RESP;
          mem_op_r     <= MEM_NONE;
          mem_wdata_r  <= 32'h0000_0000;
          resp_valid_r <= 1'b1;
          resp_rdata_r <= 32'h0000_0000;
        end
        RESP: begin
          state_r      <= IDLE;
          req_ready_r  <= 1'b1;
          resp_valid_r <= 1'b0;
          resp_rdata_r <= 32'h0000_0000;
          resp_mis_r   <= 1'b0;
          resp_oob_r   <= 1'b0;
        end
        default: begin
          state_r      <= IDLE;
          req_ready_r  <= 1'b1;
          resp_valid_r <= 1'b0;
          mem_op_r     <= MEM_NONE;
        end
      endcase
    end
  end

  assign bus.req_ready       = req_ready_r;
  assign bus.resp_valid      = resp_valid_r;
  assign bus.resp_rdata      = resp_rdata_r;
  assign bus.resp_misaligned = resp_mis_r;
  assign bus.resp_oob        = resp_oob_r;
  assign bus.mem_addr        = mem_addr_r;
  assign bus.mem_wdata       = mem_wdata_r;
  assign bus.mem_op          = mem_op_r;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: a vector table of single requests against a small
// word RAM model, plus back-to-back and reset-during-store sequences.
module tb_lsu_ctrl;
  import lsu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_ctrl_if bus ();

  lsu_ctrl #(.MEM_BYTES(16384)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // RAM model: registered address, read data valid the following cycle.
  logic [31:0] ram [0:4095];
  logic [31:0] ram_rdata = 32'h0;
  logic        pl_en = 1'b0;
  logic [11:0] pl_idx = 12'h0;
  logic [31:0] pl_val = 32'h0;

  always @(posedge clk) begin
    if (pl_en) ram[pl_idx] <= pl_val;
    else if (bus.mem_op == MEM_STORE) ram[bus.mem_addr[13:2]] <= bus.mem_wdata;
    ram_rdata <= ram[bus.mem_addr[13:2]];
  end
  assign bus.mem_rdata = ram_rdata;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic preload(input logic [11:0] idx, input logic [31:0] val);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(posedge clk); #1;
    pl_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic drive(input logic st, input lsu_width_e w, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    bus.req_valid = 1'b1; bus.req_store = st; bus.req_width = w;
    bus.req_unsigned = uns; bus.req_addr = a; bus.req_wdata = wd;
  endtask

  task automatic do_req(input logic st, input lsu_width_e w, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic mi, output logic oo,
                        output int lat, output int nld, output int nst,
                        output int stc, output logic [31:0] maddr);
    int guard = 0;
    while (!bus.req_ready && guard < 20) begin @(negedge clk); guard++; end
    drive(st, w, uns, a, wd);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rd = 32'h0; mi = 1'b0; oo = 1'b0; lat = -1; nld = 0; nst = 0; stc = -1; maddr = 32'h0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus.mem_op == MEM_LOAD) begin nld++; maddr = bus.mem_addr; end
      if (bus.mem_op == MEM_STORE) begin nst++; stc = k; maddr = bus.mem_addr; end
      if (bus.resp_valid) begin
        rd = bus.resp_rdata; mi = bus.resp_misaligned; oo = bus.resp_oob; lat = k;
        break;
      end
    end
  endtask

  typedef struct {
    logic        st;
    lsu_width_e  w;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_mis;
    logic        exp_oob;
    int          exp_lat;
    int          exp_loads;
    int          exp_stores;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs [20];

  initial begin
    logic [31:0] rd, maddr;
    logic mi, oo;
    int lat, nld, nst, stc, ready_hi, resp_cnt, r1k, r2k;
    logic [31:0] r1d, r2d;

    vecs[0]  = '{1'b0, LSU_W, 1'b0, 32'h100,  32'h0,        32'h8899AABB, 1'b0, 1'b0, 3, 2, 0, 32'h0};
    vecs[1]  = '{1'b0, LSU_B, 1'b0, 32'h101,  32'h0,        32'hFFFFFFAA, 1'b0, 1'b0, 3, 2, 0, 32'h0};
    vecs[2]  = '{1'b0, LSU_B, 1'b1, 32'h101,  32'h0,        32'h000000AA, 1'b0, 1'b0, 3, 2, 0, 32'h0};
    vecs[3]  = '{1'b0, LSU_H, 1'b0, 32'h102,  32'h0,        32'hFFFF8899, 1'b0, 1'b0, 3, 2, 0, 32'h0};
    vecs[4]  = '{1'b0, LSU_H, 1'b1, 32'h102,  32'h0,        32'h00008899, 1'b0, 1'b0, 3, 2, 0, 32'h0};
    vecs[5]  = '{1'b1, LSU_H, 1'b0, 32'h101,  32'h00005555, 32'h0,        1'b1, 1'b0, 1, 0, 0, 32'h0};
    vecs[6]  = '{1'b0, LSU_W, 1'b0, 32'h4000, 32'h0,        32'h0,        1'b0, 1'b1, 1, 0, 0, 32'h0};
    vecs[7]  = '{1'b0, LSU_W, 1'b0, 32'h4002, 32'h0,        32'h0,        1'b1, 1'b1, 1, 0, 0, 32'h0};
    vecs[8]  = '{1'b1, LSU_W, 1'b0, 32'h104,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 2, 0, 1, 32'hDEADBEEF};
    vecs[9]  = '{1'b1, LSU_B, 1'b0, 32'h102,  32'h12345655, 32'h0,        1'b0, 1'b0, 4, 2, 1, 32'h8855AABB};
    vecs[10] = '{1'b0, LSU_W, 1'b0, 32'h100,  32'h0,        32'h8855AABB, 1'b0, 1'b0, 3, 2, 0, 32'h0};
    vecs[11] = '{1'b1, LSU_H, 1'b0, 32'h106,  32'h00004321, 32'h0,        1'b0, 1'b0, 4, 2, 1, 32'h4321BEEF};
    vecs[12] = '{1'b0, LSU_H, 1'b1, 32'h106,  32'h0,        32'h00004321, 1'b0, 1'b0, 3, 2, 0, 32'h0};
    vecs[13] = '{1'b0, LSU_B, 1'b0, 32'h104,  32'h0,        32'hFFFFFFEF, 1'b0, 1'b0, 3, 2, 0, 32'h0};
    vecs[14] = '{1'b0, LSU_B, 1'b0, 32'h103,  32'h0,        32'hFFFFFF88, 1'b0, 1'b0, 3, 2, 0, 32'h0};
    vecs[15] = '{1'b1, LSU_B, 1'b0, 32'h104,  32'hAAAAAA7F, 32'h0,        1'b0, 1'b0, 4, 2, 1, 32'h4321BE7F};
    vecs[16] = '{1'b0, LSU_H, 1'b0, 32'h100,  32'h0,        32'hFFFFAABB, 1'b0, 1'b0, 3, 2, 0, 32'h0};
    vecs[17] = '{1'b0, LSU_B, 1'b0, 32'h104,  32'h0,        32'h0000007F, 1'b0, 1'b0, 3, 2, 0, 32'h0};
    vecs[18] = '{1'b0, LSU_W, 1'b0, 32'h103,  32'h0,        32'h0,        1'b1, 1'b0, 1, 0, 0, 32'h0};
    vecs[19] = '{1'b1, LSU_B, 1'b0, 32'h4000, 32'h000000FF, 32'h0,        1'b0, 1'b1, 1, 0, 0, 32'h0};

    bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_width = LSU_B;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;

    repeat (2) @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'h1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    check("rst_rdata", bus.resp_rdata, 32'h0);
    check("rst_flags", {30'h0, bus.resp_misaligned, bus.resp_oob}, 32'h0);
    check("rst_mem_op", 32'(bus.mem_op), 32'(MEM_NONE));
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    preload(12'd64, 32'h8899AABB);

    for (int i = 0; i < 20; i++) begin
      do_req(vecs[i].st, vecs[i].w, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
             rd, mi, oo, lat, nld, nst, stc, maddr);
      check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("v%0d_mis", i), 32'(mi), 32'(vecs[i].exp_mis));
      check($sformatf("v%0d_oob", i), 32'(oo), 32'(vecs[i].exp_oob));
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d_load_cycles", i), 32'(nld), 32'(vecs[i].exp_loads));
      check($sformatf("v%0d_store_cycles", i), 32'(nst), 32'(vecs[i].exp_stores));
      if (vecs[i].exp_loads + vecs[i].exp_stores > 0)
        check($sformatf("v%0d_mem_addr", i), maddr, {vecs[i].addr[31:2], 2'b00});
      if (vecs[i].exp_stores > 0) begin
        check($sformatf("v%0d_store_cycle", i), 32'(stc), 32'(vecs[i].exp_lat - 1));
        check($sformatf("v%0d_ram_word", i), ram[vecs[i].addr[13:2]], vecs[i].exp_word);
      end
    end

    // Back-to-back SB then LW with req_valid held high throughout.
    @(negedge clk);
    preload(12'd64, 32'h8899AABB);
    drive(1'b1, LSU_B, 1'b0, 32'h102, 32'h12345655);
    @(posedge clk); #1;
    drive(1'b0, LSU_W, 1'b0, 32'h100, 32'h0);
    ready_hi = 0; nst = 0; resp_cnt = 0; r1k = -1; r2k = -1; r1d = 32'h0; r2d = 32'h0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k <= 4 && bus.req_ready) ready_hi++;
      if (bus.mem_op == MEM_STORE) nst++;
      if (bus.resp_valid) begin
        resp_cnt++;
        if (resp_cnt == 1) begin r1k = k; r1d = bus.resp_rdata; end
        else begin r2k = k; r2d = bus.resp_rdata; break; end
      end
    end
    bus.req_valid = 1'b0;
    check("b2b_ready_busy", 32'(ready_hi), 32'h0);
    check("b2b_sb_latency", 32'(r1k), 32'h4);
    check("b2b_sb_rdata", r1d, 32'h0);
    check("b2b_lw_latency", 32'(r2k), 32'h8);
    check("b2b_lw_rdata", r2d, 32'h8855AABB);
    check("b2b_store_cycles", 32'(nst), 32'h1);

    // Reset asserted while the SW is in its store cycle.
    @(negedge clk);
    @(negedge clk);
    preload(12'd65, 32'hCAFEF00D);
    drive(1'b1, LSU_W, 1'b0, 32'h104, 32'h11111111);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_in_store", 32'(bus.mem_op), 32'(MEM_STORE));
    rst_n = 1'b0;
    #1;
    check("rst_mid_mem_op", 32'(bus.mem_op), 32'(MEM_NONE));
    resp_cnt = 0;
    repeat (2) begin @(negedge clk); if (bus.resp_valid) resp_cnt++; end
    rst_n = 1'b1;
    repeat (4) begin @(negedge clk); if (bus.resp_valid) resp_cnt++; end
    check("rst_mid_no_resp", 32'(resp_cnt), 32'h0);
    check("rst_mid_ready", 32'(bus.req_ready), 32'h1);
    check("rst_mid_ram_word", ram[65], 32'hCAFEF00D);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
